ice51_boot_ctrl: RTL and testbench
==================================

ICE51_BOOT_CTRL -- requirements
Module: ice51_boot_ctrl

Interface
REQ-001 SHALL have parameter MEM_SIZE, default 1024, number of code-memory bytes loaded at boot.
REQ-002 SHALL have parameter ADDR_W, default 10, code-memory address width; MEM_SIZE <= 2**ADDR_W.
REQ-003 SHALL have port i_clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port i_rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port i_rx_valid  input  1  one-cycle strobe, byte received by the UART receiver.
REQ-006 SHALL have port i_rx_data  input  8  received byte, valid with i_rx_valid.
REQ-007 SHALL have port o_mem_we  output  1  code-memory write strobe.
REQ-008 SHALL have port o_mem_addr  output  ADDR_W  code-memory write address.
REQ-009 SHALL have port o_mem_data  output  8  code-memory write data.
REQ-010 SHALL have port o_core_rst  output  1  active-high reset for the 8051 core.
REQ-011 SHALL have port o_boot_done  output  1  high once the image is fully loaded.
REQ-012 SHALL have port o_cpu_rx_valid  output  1  forwarded received-byte strobe to the core.
REQ-013 SHALL have port o_cpu_rx_data  output  8  forwarded received byte.
REQ-014 SHALL have port i_cpu_tx_valid  input  1  core requests a byte transmit.
REQ-015 SHALL have port i_cpu_tx_data  input  8  core transmit byte.
REQ-016 SHALL have port o_cpu_tx_ready  output  1  core transmit byte accepted this cycle.
REQ-017 SHALL have port o_tx_valid  output  1  byte offered to the UART transmitter.
REQ-018 SHALL have port o_tx_data  output  8  byte offered to the UART transmitter.
REQ-019 SHALL have port i_tx_ready  input  1  UART transmitter accepts byte this cycle.

Function
REQ-020 SHALL implement states LOAD, RELEASE, RUN; LOAD entered from reset.
REQ-021 In LOAD, each i_rx_valid SHALL produce o_mem_we=1 on the next cycle with o_mem_addr=byte count and o_mem_data=i_rx_data (latency 1), then increment count.
REQ-022 Acceptance of byte number MEM_SIZE-1 SHALL move LOAD->RELEASE; count SHALL never exceed MEM_SIZE-1 or wrap.
REQ-023 RELEASE SHALL last until the last memory write has completed and the echo buffer (if present) is empty, minimum 1 cycle, then move to RUN.
REQ-024 o_core_rst SHALL be 1 in LOAD and RELEASE, 0 in RUN; o_boot_done SHALL be 1 only in RUN.
REQ-025 In RUN, o_mem_we SHALL stay 0; each i_rx_valid SHALL produce o_cpu_rx_valid=1 for one cycle on the next cycle with o_cpu_rx_data=i_rx_data.
REQ-026 o_cpu_rx_valid SHALL stay 0 in LOAD and RELEASE; bytes received in RELEASE SHALL be dropped.
REQ-027 Transmit handshake: byte transfers when o_tx_valid and i_tx_ready both 1; o_tx_valid/o_tx_data SHALL hold stable until transfer.
REQ-028 In RUN, core transmit SHALL pass through: o_tx_valid=i_cpu_tx_valid, o_tx_data=i_cpu_tx_data, o_cpu_tx_ready=i_tx_ready, unless echo buffer is full (echo priority).
REQ-029 o_cpu_tx_ready SHALL be 0 outside RUN.

Reset
REQ-030 i_rst high at a rising edge SHALL force state LOAD, count 0, echo buffer empty, o_core_rst=1 and all other outputs 0, including mid-load and mid-RUN.
REQ-031 Reset mid-load SHALL restart loading at address 0; no partial resume.

Configuration
REQ-032 Macro BOOT_ECHO_EN defined: each byte accepted in LOAD SHALL be stored in a one-entry echo buffer and offered on o_tx_* the next cycle until transferred.
REQ-033 With BOOT_ECHO_EN, a byte arriving while the echo buffer is full SHALL still be written to memory but not echoed (echo dropped).
REQ-034 Macro BOOT_ECHO_EN undefined: no echo buffer; o_tx_valid=0 outside RUN; RELEASE lasts exactly 1 cycle.

Verification
REQ-035 Reset, then MEM_SIZE=4 bytes 0x11,0x22,0x33,0x44 -> writes addr 0..3 with those data, each 1 cycle after strobe; o_core_rst falls, o_boot_done rises after RELEASE.
REQ-036 In RUN, rx byte 0xA5 -> o_cpu_rx_valid=1, o_cpu_rx_data=0xA5 next cycle, o_mem_we stays 0.
REQ-037 In RUN, i_cpu_tx_valid=1 data 0x5A, i_tx_ready=0 for 3 cycles then 1 -> o_tx_data=0x5A stable, o_cpu_tx_ready=1 only on ready cycle.
REQ-038 i_rst pulsed after 2 of 4 bytes loaded, then 4 bytes 0x01..0x04 -> writes restart at addr 0; core released only after 4th new byte.
REQ-039 BOOT_ECHO_EN, i_tx_ready=0, bytes 0x10 then 0x20 loaded -> 0x10 echoed, 0x20 written to memory but not echoed; RUN entered only after echo transfer.
REQ-040 i_cpu_tx_valid=1 during LOAD -> o_cpu_tx_ready=0, no core byte reaches o_tx_data.

Source files
------------

// File: rtl/ice51_boot_ctrl.sv
// ---------------------------------------------------------------------------
// ice51_boot_ctrl
//
// Boot controller for the ice51 8051 system. After reset the controller
// holds the core in reset and copies the first MEM_SIZE bytes that arrive
// from the UART receiver into code memory, at addresses 0 .. MEM_SIZE-1.
// It then spends at least one cycle in RELEASE, letting the final memory
// write and any pending echo finish. After that it releases the core.
// From then on, received bytes go to the core and the core's transmit
// requests pass straight through to the UART transmitter.
//
// Optional feature (macro BOOT_ECHO_EN):
//   Each byte loaded into memory is also echoed back on the transmit port
//   through a one-entry buffer. A byte that arrives while the buffer is
//   full is still written to memory but is not echoed.
//
// Parameters:
//   MEM_SIZE  number of code-memory bytes loaded at boot
//   ADDR_W    code-memory address width (MEM_SIZE <= 2**ADDR_W)
//
// Ports:
//   i_clk           clock, all logic on the rising edge
//   i_rst           synchronous active-high reset
//   i_rx_valid      one-cycle strobe for a received byte
//   i_rx_data       received byte
//   o_mem_we        code-memory write strobe
//   o_mem_addr      code-memory write address
//   o_mem_data      code-memory write data
//   o_core_rst      reset for the 8051 core (high until boot completes)
//   o_boot_done     high once the image is fully loaded
//   o_cpu_rx_valid  received-byte strobe forwarded to the core
//   o_cpu_rx_data   received byte forwarded to the core
//   i_cpu_tx_valid  core requests a byte transmit
//   i_cpu_tx_data   core transmit byte
//   o_cpu_tx_ready  core transmit byte accepted this cycle
//   o_tx_valid      byte offered to the UART transmitter
//   o_tx_data       byte offered to the UART transmitter
//   i_tx_ready      UART transmitter accepts the byte this cycle
// ---------------------------------------------------------------------------
module ice51_boot_ctrl #(
  parameter int MEM_SIZE = 1024,
  parameter int ADDR_W   = 10
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rx_valid,
  input  logic [7:0]        i_rx_data,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [7:0]        o_mem_data,
  output logic              o_core_rst,
  output logic              o_boot_done,
  output logic              o_cpu_rx_valid,
  output logic [7:0]        o_cpu_rx_data,
  input  logic              i_cpu_tx_valid,
  input  logic [7:0]        i_cpu_tx_data,
  output logic              o_cpu_tx_ready,
  output logic              o_tx_valid,
  output logic [7:0]        o_tx_data,
  input  logic              i_tx_ready
);

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_RELEASE,
    ST_RUN
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_SIZE - 1);

  state_t            state;
  logic [ADDR_W-1:0] count;      // address of the next byte to load
  logic              echo_full;
  logic [7:0]        echo_data;

`ifdef BOOT_ECHO_EN
  // The echo buffer fills only from bytes accepted in LOAD. A byte that
  // arrives while the buffer is full is dropped from the echo path, even if
  // the buffered byte drains in that same cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      echo_full <= 1'b0;
    end else if (state == ST_LOAD && i_rx_valid && !echo_full) begin
      echo_full <= 1'b1;
    end else if (echo_full && i_tx_ready) begin
      echo_full <= 1'b0;
    end
  end

  // NOTE: a pure data register that is qualified by a valid flag needs no
  // reset. Only echo_full has to be cleared.
  always_ff @(posedge i_clk) begin
    if (state == ST_LOAD && i_rx_valid && !echo_full) begin
      echo_data <= i_rx_data;
    end
  end
`else
  assign echo_full = 1'b0;
  assign echo_data = 8'h00;
`endif

  // Main sequencer. All memory and core-facing outputs are registered here.
  // NOTE: sequential state is updated only with non-blocking assignments, so
  // every branch sees the values from before this clock edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state          <= ST_LOAD;
      count          <= '0;
      o_mem_we       <= 1'b0;
      o_mem_addr     <= '0;
      o_mem_data     <= 8'h00;
      o_core_rst     <= 1'b1;
      o_boot_done    <= 1'b0;
      o_cpu_rx_valid <= 1'b0;
      o_cpu_rx_data  <= 8'h00;
    end else begin
      o_mem_we       <= 1'b0;
      o_cpu_rx_valid <= 1'b0;
      case (state)
        ST_LOAD: begin
          if (i_rx_valid) begin
            o_mem_we   <= 1'b1;
            o_mem_addr <= count;
            o_mem_data <= i_rx_data;
            // The count stops at the last address, so it can never wrap.
            if (count == LAST_ADDR) begin
              state <= ST_RELEASE;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        ST_RELEASE: begin
          // The final write strobe is active during this cycle. Received
          // bytes are dropped while we wait for the echo to drain.
          if (!echo_full) begin
            state       <= ST_RUN;
            o_core_rst  <= 1'b0;
            o_boot_done <= 1'b1;
          end
        end
        ST_RUN: begin
          if (i_rx_valid) begin
            o_cpu_rx_valid <= 1'b1;
            o_cpu_rx_data  <= i_rx_data;
          end
        end
        default: begin
          state <= ST_LOAD;
        end
      endcase
    end
  end

  // Transmit mux. A pending echo has priority. Otherwise the core's request
  // passes straight through once the core is running.
  // NOTE: every output of a combinational block gets a default value first,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    o_tx_valid     = 1'b0;
    o_tx_data      = 8'h00;
    o_cpu_tx_ready = 1'b0;
    if (echo_full) begin
      o_tx_valid = 1'b1;
      o_tx_data  = echo_data;
    end else if (state == ST_RUN) begin
      o_tx_valid     = i_cpu_tx_valid;
      o_tx_data      = i_cpu_tx_data;
      o_cpu_tx_ready = i_tx_ready;
    end
  end

endmodule

// File: tb/tb_ice51_boot_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ice51_boot_ctrl
//
// Self-checking bench for ice51_boot_ctrl (MEM_SIZE=4, ADDR_W=3).
//
// A behavioural model tracks three things: how many image bytes have been
// loaded, whether the core is running, and what sits in the echo buffer.
// A compare process checks every output on each falling edge. Directed
// scenarios pin the model with literal expectations. A randomized phase
// then exercises loading, running and resets in arbitrary interleavings.
// Build with +define+BOOT_ECHO_EN to cover the echo variant.
// ---------------------------------------------------------------------------
module tb_ice51_boot_ctrl;

  localparam int MEM_SIZE = 4;
  localparam int ADDR_W   = 3;
`ifdef BOOT_ECHO_EN
  localparam bit ECHO = 1'b1;
`else
  localparam bit ECHO = 1'b0;
`endif

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic              i_rx_valid;
  logic [7:0]        i_rx_data;
  logic              o_mem_we;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [7:0]        o_mem_data;
  logic              o_core_rst;
  logic              o_boot_done;
  logic              o_cpu_rx_valid;
  logic [7:0]        o_cpu_rx_data;
  logic              i_cpu_tx_valid;
  logic [7:0]        i_cpu_tx_data;
  logic              o_cpu_tx_ready;
  logic              o_tx_valid;
  logic [7:0]        o_tx_data;
  logic              i_tx_ready;

  int n_checks = 0;
  int n_errors = 0;

  ice51_boot_ctrl #(.MEM_SIZE(MEM_SIZE), .ADDR_W(ADDR_W)) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_rx_valid     (i_rx_valid),
    .i_rx_data      (i_rx_data),
    .o_mem_we       (o_mem_we),
    .o_mem_addr     (o_mem_addr),
    .o_mem_data     (o_mem_data),
    .o_core_rst     (o_core_rst),
    .o_boot_done    (o_boot_done),
    .o_cpu_rx_valid (o_cpu_rx_valid),
    .o_cpu_rx_data  (o_cpu_rx_data),
    .i_cpu_tx_valid (i_cpu_tx_valid),
    .i_cpu_tx_data  (i_cpu_tx_data),
    .o_cpu_tx_ready (o_cpu_tx_ready),
    .o_tx_valid     (o_tx_valid),
    .o_tx_data      (o_tx_data),
    .i_tx_ready     (i_tx_ready)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after a rising edge, so they are stable for
  // both the next falling edge and the next rising edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  int       m_loaded;      // image bytes accepted so far
  bit       m_run;         // core released
  bit       m_echo_full;
  bit [7:0] m_echo;
  bit       m_ok = 1'b0;   // model synchronised by a reset
  bit       e_we, e_cpu_rx_v;
  bit [7:0] e_mem_data, e_cpu_rx_d;
  int       e_addr;

  // Advance the model by one rising edge, using the current input values.
  task automatic model_step();
    bit loading, old_full;
    if (i_rst) begin
      m_loaded = 0; m_run = 1'b0; m_echo_full = 1'b0;
      e_we = 1'b0; e_addr = 0; e_mem_data = 8'h00;
      e_cpu_rx_v = 1'b0; e_cpu_rx_d = 8'h00;
      m_ok = 1'b1;
      return;
    end
    loading  = (m_loaded < MEM_SIZE);
    old_full = m_echo_full;
    e_we = 1'b0;
    e_cpu_rx_v = 1'b0;
    if (loading && i_rx_valid) begin
      e_we = 1'b1; e_addr = m_loaded; e_mem_data = i_rx_data;
      m_loaded++;
    end
    if (ECHO) begin
      if (old_full && i_tx_ready) m_echo_full = 1'b0;
      if (loading && i_rx_valid && !old_full) begin
        m_echo_full = 1'b1; m_echo = i_rx_data;
      end
    end
    if (m_run) begin
      if (i_rx_valid) begin e_cpu_rx_v = 1'b1; e_cpu_rx_d = i_rx_data; end
    end else if (!loading && !old_full) begin
      m_run = 1'b1;  // image complete for at least one cycle, echo drained
    end
  endtask

  // Compare on every falling edge, then advance the model for the next edge.
  initial begin
    forever begin
      @(negedge i_clk);
      if (m_ok) begin
        check("mem_we", o_mem_we, e_we);
        if (e_we) begin
          check("mem_addr", o_mem_addr, e_addr);
          check("mem_data", o_mem_data, e_mem_data);
        end
        check("cpu_rx_valid", o_cpu_rx_valid, e_cpu_rx_v);
        if (e_cpu_rx_v) check("cpu_rx_data", o_cpu_rx_data, e_cpu_rx_d);
        check("core_rst", o_core_rst, !m_run);
        check("boot_done", o_boot_done, m_run);
        if (m_echo_full) begin
          check("tx_valid", o_tx_valid, 1);
          check("tx_data", o_tx_data, m_echo);
          check("cpu_tx_ready", o_cpu_tx_ready, 0);
        end else if (m_run) begin
          check("tx_valid", o_tx_valid, i_cpu_tx_valid);
          check("tx_data", o_tx_data, i_cpu_tx_data);
          check("cpu_tx_ready", o_cpu_tx_ready, i_tx_ready);
        end else begin
          check("tx_valid", o_tx_valid, 0);
          check("tx_data", o_tx_data, 0);
          check("cpu_tx_ready", o_cpu_tx_ready, 0);
        end
      end
      model_step();
    end
  end

  task automatic wait_done(input string name);
    int n = 0;
    while (o_boot_done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) check({name, " boot_done timeout"}, o_boot_done, 1);
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
  endtask

  // ---------------- directed and random stimulus ----------------
  initial begin
    bit [7:0] img [4];
    i_rst = 1'b1; i_rx_valid = 1'b0; i_rx_data = 8'h00;
    i_cpu_tx_valid = 1'b0; i_cpu_tx_data = 8'h00; i_tx_ready = 1'b0;
    tick();
    tick();
    // Reset state
    check("rst core_rst", o_core_rst, 1);
    check("rst boot_done", o_boot_done, 0);
    check("rst mem_we", o_mem_we, 0);
    check("rst mem_addr", o_mem_addr, 0);
    check("rst cpu_rx_valid", o_cpu_rx_valid, 0);
    check("rst tx_valid", o_tx_valid, 0);
    check("rst cpu_tx_ready", o_cpu_tx_ready, 0);
    i_rst = 1'b0;

    // Load 11 22 33 44 while the core tries to transmit
    img[0] = 8'h11; img[1] = 8'h22; img[2] = 8'h33; img[3] = 8'h44;
    i_cpu_tx_valid = 1'b1; i_cpu_tx_data = 8'hC3; i_tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      i_rx_valid = 1'b1; i_rx_data = img[i];
      tick();
      check("load we", o_mem_we, 1);
      check("load addr", o_mem_addr, i);
      check("load data", o_mem_data, img[i]);
      check("load cpu_tx_ready", o_cpu_tx_ready, 0);
      if (!ECHO) check("load tx_valid", o_tx_valid, 0);
      if (!ECHO) check("load tx_data", o_tx_data, 0);
    end
    i_rx_valid = 1'b0;
    check("release core_rst", o_core_rst, 1);
    check("release boot_done", o_boot_done, 0);
    if (!ECHO) begin
      tick();
      check("run core_rst", o_core_rst, 0);
      check("run boot_done", o_boot_done, 1);
    end
    wait_done("load1");
    i_cpu_tx_valid = 1'b0;

    // Receive in RUN
    i_rx_valid = 1'b1; i_rx_data = 8'hA5;
    tick();
    i_rx_valid = 1'b0;
    check("run cpu_rx_valid", o_cpu_rx_valid, 1);
    check("run cpu_rx_data", o_cpu_rx_data, 8'hA5);
    check("run mem_we", o_mem_we, 0);
    tick();
    check("run cpu_rx_valid pulse", o_cpu_rx_valid, 0);

    // Transmit back-pressure in RUN
    i_cpu_tx_valid = 1'b1; i_cpu_tx_data = 8'h5A; i_tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp tx_valid", o_tx_valid, 1);
      check("bp tx_data", o_tx_data, 8'h5A);
      check("bp cpu_tx_ready", o_cpu_tx_ready, 0);
      tick();
    end
    i_tx_ready = 1'b1;
    #1;
    check("bp tx_data final", o_tx_data, 8'h5A);
    check("bp cpu_tx_ready", o_cpu_tx_ready, 1);
    tick();
    i_cpu_tx_valid = 1'b0; i_tx_ready = 1'b0;

    // Reset in the middle of a load
    do_reset();
    for (int i = 0; i < 2; i++) begin
      i_rx_valid = 1'b1; i_rx_data = 8'hAA + 8'(i);
      tick();
    end
    i_rx_valid = 1'b0;
    i_tx_ready = 1'b1;
    do_reset();
    check("midload core_rst", o_core_rst, 1);
    for (int i = 0; i < 4; i++) begin
      i_rx_valid = 1'b1; i_rx_data = 8'(i + 1);
      tick();
      check("reload addr", o_mem_addr, i);
      check("reload data", o_mem_data, i + 1);
      if (i == 2) check("reload core_rst held", o_core_rst, 1);
    end
    i_rx_valid = 1'b0;
    wait_done("reload");

`ifdef BOOT_ECHO_EN
    // Echo with a stalled transmitter
    i_tx_ready = 1'b0;
    do_reset();
    i_rx_valid = 1'b1; i_rx_data = 8'h10;
    tick();
    i_rx_data = 8'h20;
    tick();
    check("echo we", o_mem_we, 1);
    check("echo addr", o_mem_addr, 1);
    check("echo mem_data", o_mem_data, 8'h20);
    check("echo tx_data", o_tx_data, 8'h10);
    i_rx_data = 8'h30;
    tick();
    i_rx_data = 8'h40;
    tick();
    i_rx_valid = 1'b0;
    tick();
    tick();
    check("echo hold core_rst", o_core_rst, 1);
    check("echo hold tx_data", o_tx_data, 8'h10);
    i_tx_ready = 1'b1;
    tick();
    check("echo drained", o_tx_valid, 0);
    check("echo core_rst still held", o_core_rst, 1);
    wait_done("echo");
`endif

    // Randomized traffic with occasional resets
    for (int r = 0; r < 8; r++) begin
      do_reset();
      for (int c = 0; c < 60; c++) begin
        i_rx_valid     = ($urandom_range(0, 2) == 0);
        i_rx_data      = 8'($urandom);
        i_cpu_tx_valid = 1'($urandom_range(0, 1));
        i_cpu_tx_data  = 8'($urandom);
        i_tx_ready     = 1'($urandom_range(0, 1));
        i_rst          = ($urandom_range(0, 63) == 0);
        tick();
      end
      i_rst = 1'b0;
    end

    i_rx_valid = 1'b0; i_cpu_tx_valid = 1'b0; i_tx_ready = 1'b0;
    tick();
    tick();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1, "watchdog");
  end

endmodule
